// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   access_type_t    : load/store access size encoding (2'b11 is illegal)
//   dmem_state_t     : responder FSM states
//   dmem_req_t       : captured request
//   access_misaligned: alignment / illegal-size check for an access
package dmem_pkg;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'b00,
    ACC_HALF = 2'b01,
    ACC_WORD = 2'b10
  } access_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  // Size is kept as raw bits so the illegal encoding survives capture.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } dmem_req_t;

  // 1 when the access is misaligned for its size, or the size is illegal.
  function automatic logic access_misaligned(logic [1:0] size, logic [1:0] offset);
    logic bad;
    case (size)
      ACC_BYTE: bad = 1'b0;
      ACC_HALF: bad = offset[0];
      ACC_WORD: bad = |offset;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Combinational byte-lane unit: little-endian load extraction and store merge.
//   old_word   : current storage word
//   offset     : byte offset within the word (addr[1:0])
//   size       : access size (access_type_t encoding)
//   sign_ext   : sign-extend byte/half loads
//   wdata      : right-aligned store data
//   load_data  : aligned, extended load result
//   store_word : old_word with the addressed lanes replaced by wdata
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [4:0]  byte_lsb;
  logic [4:0]  half_lsb;

  // Halves always start on an even lane, so offset[0] is dropped for them.
  assign byte_lsb = {offset, 3'b000};
  assign half_lsb = {offset[1], 4'b0000};
  assign byte_val = old_word[byte_lsb +: 8];
  assign half_val = old_word[half_lsb +: 16];

  always_comb begin
    load_data  = '0;
    store_word = old_word;
    case (size)
      ACC_BYTE: begin
        load_data                 = {{24{sign_ext & byte_val[7]}}, byte_val};
        store_word[byte_lsb +: 8] = wdata[7:0];
      end
      ACC_HALF: begin
        load_data                  = {{16{sign_ext & half_val[15]}}, half_val};
        store_word[half_lsb +: 16] = wdata[15:0];
      end
      ACC_WORD: begin
        load_data  = old_word;
        store_word = wdata;
      end
      default: begin
        load_data  = '0;
        store_word = old_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
//   clock, reset          : posedge clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_write, req_type   : store flag and access size
//   req_signed            : sign-extend byte/half loads
//   req_addr, req_wdata   : byte address and right-aligned store data
//   req_pc                : issuing pc, used for the store trace only
//   resp_valid/resp_ready : response handshake
//   resp_data, resp_error : load result (0 for stores/errors) and error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_type,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_error
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LoadCount = 4'(LATENCY - 1);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, in_req, cur;
  logic        req_ready_q;
  logic [31:0] resp_data_q;
  logic        resp_error_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          err;
  logic          out_of_range;
  logic          mem_we;
  logic [AW-1:0] word_idx;
  logic [31:0]   old_word;
  logic [31:0]   load_data;
  logic [31:0]   store_word;

  assign in_req = '{
    write:    req_write,
    size:     req_type,
    sign_ext: req_signed,
    addr:     req_addr,
    wdata:    req_wdata,
    pc:       req_pc
  };

  // req_ready_q is only ever set while the FSM is in IDLE.
  assign accept = req_valid & req_ready_q;

  // With LATENCY=1 the commit edge is the accept edge, so the live request is used.
  assign cur = (state_q == IDLE) ? in_req : req_q;

  assign word_idx     = cur.addr[AW+1:2];
  assign out_of_range = |(cur.addr >> (AW + 2));
  assign err          = access_misaligned(cur.size, cur.addr[1:0]) | out_of_range;
  assign old_word     = mem[word_idx];

  dmem_byte_lane u_byte_lane (
    .old_word   (old_word),
    .offset     (cur.addr[1:0]),
    .size       (cur.size),
    .sign_ext   (cur.sign_ext),
    .wdata      (cur.wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = LoadCount;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Store and load both act on the edge that enters RESP.
  assign mem_we = enter_resp & cur.write & ~err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == IDLE);
      if (accept) begin
        req_q <= in_req;
      end
      if (enter_resp) begin
        resp_data_q  <= (err || cur.write) ? 32'h0 : load_data;
        resp_error_q <= err;
      end else if (state_q == RESP && resp_ready) begin
        resp_data_q  <= '0;
        resp_error_q <= 1'b0;
      end
    end
  end

  // Storage has no reset; mem_we cannot fire while reset holds the FSM idle.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[word_idx] <= store_word;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (mem_we) begin
      $display("dmem store pc=%08h addr=%08h word=%08h", cur.pc, cur.addr, store_word);
    end
  end
`endif

  assign req_ready  = req_ready_q;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_error;

  always #5 clock = ~clock;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_type   (req_type),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_error (resp_error)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [7:0] model_mem [DEPTH*4];
  int   lat_cnt = 0;
  bit   in_flight = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: a flat little-endian byte array.
  task automatic model_access(input bit wr, input logic [1:0] ty, input bit sg,
                              input logic [31:0] a, input logic [31:0] wd, output exp_t r);
    int unsigned size;
    logic [31:0] v;
    size   = (ty == 2'd0) ? 1 : (ty == 2'd1) ? 2 : 4;
    r.data = 32'h0;
    r.err  = 1'b0;
    if (ty == 2'd3 || (a % size) != 0 || a >= DEPTH * 4) begin
      r.err = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < int'(size); i++) model_mem[a + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(size); i++) v = v | (32'(model_mem[a + i]) << (8 * i));
      if (sg && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sg && size == 2 && v[15]) v = v | 32'hFFFF_0000;
      r.data = v;
    end
  endtask

  // Monitor: consumes responses from the scoreboard and measures latency.
  always @(posedge clock) begin
    exp_t e;
    if (reset) begin
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got data %08h with empty scoreboard", resp_data);
        end else begin
          e = sb_q.pop_front();
          check32("resp_data", resp_data, e.data);
          check32("resp_error", {31'b0, resp_error}, {31'b0, e.err});
        end
      end
      if (req_valid && req_ready) begin
        in_flight = 1'b1;
        lat_cnt   = 1;
      end else if (in_flight) begin
        lat_cnt++;
      end
      #1;
      if (in_flight && resp_valid && reset) begin
        check32("latency", 32'(lat_cnt), 32'(LAT));
        in_flight = 1'b0;
      end
    end else begin
      in_flight = 1'b0;
    end
  end

  task automatic issue(input bit wr, input logic [1:0] ty, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit track = 1'b1);
    int   t;
    exp_t r;
    t = 0;
    @(negedge clock);
    while (!req_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_type   = ty;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_pc     = $urandom;
    if (track) begin
      model_access(wr, ty, sg, a, wd, r);
      sb_q.push_back(r);
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || !req_ready) && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (sb_q.size() != 0 || !req_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  initial begin
    int          t;
    bit          wr;
    logic [1:0]  ty;
    logic [31:0] a;

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clock);
      check32("rst_req_ready", {31'b0, req_ready}, 32'h0);
      check32("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    end
    reset = 1'b1;
    @(posedge clock);
    #1 check32("ready_after_reset", {31'b0, req_ready}, 32'h1);

    // Word store/load, sub-word loads.
    issue(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF);
    issue(1, 2'd2, 0, 32'h14, 32'hCAFE_BABE);
    issue(1, 2'd2, 0, 32'h20, 32'h1122_3344);
    issue(0, 2'd2, 0, 32'h10, 32'h0);
    issue(0, 2'd0, 1, 32'h13, 32'h0);
    issue(0, 2'd0, 0, 32'h13, 32'h0);
    issue(0, 2'd1, 1, 32'h12, 32'h0);
    issue(0, 2'd1, 0, 32'h10, 32'h0);

    // Lane merge.
    issue(1, 2'd0, 0, 32'h11, 32'hFFFF_FF5A);
    issue(1, 2'd1, 0, 32'h12, 32'hABCD_1234);
    issue(0, 2'd2, 0, 32'h10, 32'h0);

    // Error cases.
    issue(0, 2'd2, 0, 32'h12, 32'h0);
    issue(1, 2'd2, 0, 32'h16, 32'h5555_5555);
    issue(0, 2'd2, 0, 32'h14, 32'h0);
    issue(0, 2'd2, 0, DEPTH * 4, 32'h0);
    issue(0, 2'd3, 0, 32'h10, 32'h0);
    issue(1, 2'd1, 0, 32'h11, 32'h7777_7777);
    issue(0, 2'd2, 0, 32'h10, 32'h0);
    drain();

    // Backpressure: response must hold for three cycles.
    resp_ready = 1'b0;
    issue(0, 2'd2, 0, 32'h14, 32'h0);
    t = 0;
    while (!resp_valid && t < 20) begin
      @(negedge clock);
      t++;
    end
    repeat (3) begin
      @(negedge clock);
      check32("bp_resp_valid", {31'b0, resp_valid}, 32'h1);
      check32("bp_resp_data", resp_data, (sb_q.size() != 0) ? sb_q[0].data : 32'hFFFF_FFFF);
      check32("bp_req_ready", {31'b0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    drain();

    // Reset during BUSY of a store: the store is never committed.
    issue(1, 2'd2, 0, 32'h20, 32'h0BAD_F00D, 1'b0);
    reset = 1'b0;
    #1;
    check32("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check32("midrst_req_ready", {31'b0, req_ready}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 check32("midrst_ready_after", {31'b0, req_ready}, 32'h1);
    issue(0, 2'd2, 0, 32'h20, 32'h0);
    drain();

    // Randomized traffic over a prefilled region.
    for (int w = 0; w < 16; w++) issue(1, 2'd2, 0, 32'(w * 4), $urandom);
    for (int n = 0; n < 200; n++) begin
      wr = 1'($urandom_range(0, 1));
      ty = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = DEPTH * 4 + $urandom_range(0, 255);
      else a = $urandom_range(0, 63);
      issue(wr, ty, 1'($urandom_range(0, 1)), a, $urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
